ped_req_cond: RTL and testbench
===============================

PED_REQ_COND -- requirements
Module: ped_req_cond

Interface
REQ-001 Parameter DB_CYCLES, default 16: consecutive cycles a synchronized input must differ from its debounced value before the debounced value updates (range 2..255).
REQ-002 Parameter HOLDOFF_CYCLES, default 64: post-acknowledge lockout length in cycles, used only when the REQ-022 macro is defined (range 1..65535).
REQ-003 Single clock; reset is synchronous and active-low.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-low reset.
REQ-006 Cm, Cc  input  1 each  raw main/country road vehicle sensors, asynchronous.
REQ-007 PQm, PQc  input  1 each  raw main/country pedestrian buttons, asynchronous, bouncy.
REQ-008 peak  input  1  raw peak-hour switch, asynchronous.
REQ-009 ack_m, ack_c  input  1 each  controller acknowledge: pedestrian phase granted.
REQ-010 cm_s, cc_s, peak_s  output  1 each  debounced levels.
REQ-011 req_m, req_c  output  1 each  latched pedestrian requests.
REQ-012 peak_chg  output  1  one-cycle pulse on any debounced peak edge.

Function
REQ-013 Each of the five raw inputs shall pass through a 2-flop synchronizer, then an independent debounce cell.
REQ-014 Debounce cell: synchronized value equal to stable value -> counter cleared; otherwise counter increments; when the counter reaches DB_CYCLES-1 while still differing, stable value toggles and counter clears in the same cycle.
REQ-015 Latency: a raw level change held steady updates the debounced output exactly DB_CYCLES+2 rising edges later; any glitch shorter than DB_CYCLES cycles produces no output change.
REQ-016 Counter width shall be ceil(log2(DB_CYCLES)); the counter never exceeds DB_CYCLES-1 and never wraps.
REQ-017 req_m sets on the cycle after a debounced PQm rising edge and holds until ack_m is sampled high, clearing on the next edge; req_c identical with PQc/ack_c.
REQ-018 Debounced rising edge and ack in the same cycle: the request stays/becomes set (new press wins).
REQ-019 ack with no pending request: no effect; repeated presses while pending: no effect, request stays set.
REQ-020 peak_chg pulses exactly one cycle after each debounced peak_s transition, rising or falling.

Reset
REQ-021 rst low at a clock edge: synchronizer flops, stable values, counters, req_m, req_c, peak_chg and holdoff timers all 0 on that edge, including mid-debounce or mid-holdoff; first input sampling on the first edge with rst high.

Configuration
REQ-022 Macro TRAFFIC_PQ_HOLDOFF_EN defined: after a request clears via ack, debounced rising edges on that direction are ignored for HOLDOFF_CYCLES cycles (per-direction 16-bit down-counter); a rising edge on the cycle the counter reaches 0 is accepted.
REQ-023 Macro undefined: no holdoff logic or counter is synthesized; a rising edge the cycle after clearing re-sets the request.

Structure
REQ-024 Shared package traffic_pkg holds DB_CYCLES and HOLDOFF_CYCLES defaults and the index constants for the five conditioned inputs.
REQ-025 One sub-module debounce_cell (synchronizer + counter + stable flop + rise/fall pulses), instantiated five times; request latches and holdoff logic remain in ped_req_cond.

Verification
REQ-026 DB_CYCLES=4: Cm 0->1 held -> cm_s rises exactly 6 edges later; cc_s, peak_s unchanged.
REQ-027 DB_CYCLES=4: PQm pulses high 3 cycles, five times with 1-cycle gaps -> req_m stays 0.
REQ-028 PQm held 10 cycles -> req_m=1 one cycle after debounce; ack_m high 1 cycle -> req_m=0 next edge; req_c never moves.
REQ-029 Debounced PQc rise coincident with ack_c while req_c=1 -> req_c remains 1.
REQ-030 Macro defined, HOLDOFF_CYCLES=8: ack_m clears req_m, new debounced press 3 cycles later -> ignored; press after 8 cycles -> req_m=1. Macro undefined: press 3 cycles later -> req_m=1.
REQ-031 rst low for one edge mid-debounce with req_m=1 -> all outputs 0 next edge; debounce restarts from zero count after release.

Source files
------------

// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared constants for the pedestrian request conditioner.
//   DB_CYCLES_DEF      default debounce length in cycles
//   HOLDOFF_CYCLES_DEF default post-acknowledge lockout length in cycles
//   IDX_*              bit position of each conditioned input in the
//                      packed raw/debounced vectors used by ped_req_cond
// ---------------------------------------------------------------------------
package traffic_pkg;

  localparam int DB_CYCLES_DEF      = 16;
  localparam int HOLDOFF_CYCLES_DEF = 64;

  localparam int IDX_CM   = 0;
  localparam int IDX_CC   = 1;
  localparam int IDX_PQM  = 2;
  localparam int IDX_PQC  = 3;
  localparam int IDX_PEAK = 4;
  localparam int NUM_IN   = 5;

  // Direction indices for the two pedestrian request latches.
  localparam int DIR_M  = 0;
  localparam int DIR_C  = 1;
  localparam int NUM_DIR = 2;

endpackage

// File: rtl/debounce_cell.sv
// ---------------------------------------------------------------------------
// debounce_cell
// Two-flop synchronizer followed by a saturating-count debouncer.
// The stable value toggles once the synchronized input has disagreed with
// it for DB_CYCLES consecutive cycles; rise/fall are one-cycle pulses that
// are high in the first cycle the new stable value is visible.
//   clk   in   system clock
//   rst   in   synchronous active-low reset
//   din   in   raw asynchronous input
//   dout  out  debounced level
//   rise  out  pulse: dout just went 0->1
//   fall  out  pulse: dout just went 1->0
// ---------------------------------------------------------------------------
module debounce_cell
  import traffic_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int              CNT_W   = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;
  logic             differ;

  assign differ = (sync_p1 != dout);

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      dout    <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      // synchronizer stage 0 -> stage 1
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      // debounce stage: count disagreement, toggle at the terminal count
      rise    <= 1'b0;
      fall    <= 1'b0;
      if (!differ) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt  <= '0;
        dout <= ~dout;
        rise <= ~dout;
        fall <= dout;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ped_req_cond.sv
// ---------------------------------------------------------------------------
// ped_req_cond
// Conditions the raw traffic-controller inputs: every sensor, button and the
// peak switch is synchronized and debounced; debounced pedestrian presses
// are latched as requests until the controller acknowledges them; any
// debounced peak edge produces a one-cycle pulse.
// Optional feature: define TRAFFIC_PQ_HOLDOFF_EN to ignore new presses on a
// direction for HOLDOFF_CYCLES cycles after its request was acknowledged.
//   clk            in   system clock
//   rst            in   synchronous active-low reset
//   Cm, Cc         in   raw vehicle sensors (main / country)
//   PQm, PQc       in   raw pedestrian buttons (main / country)
//   peak           in   raw peak-hour switch
//   ack_m, ack_c   in   pedestrian phase granted (main / country)
//   cm_s, cc_s     out  debounced vehicle sensors
//   peak_s         out  debounced peak switch
//   req_m, req_c   out  latched pedestrian requests
//   peak_chg       out  one-cycle pulse after each debounced peak edge
// ---------------------------------------------------------------------------
module ped_req_cond
  import traffic_pkg::*;
#(
  parameter int DB_CYCLES      = DB_CYCLES_DEF,
  parameter int HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic Cm,
  input  logic Cc,
  input  logic PQm,
  input  logic PQc,
  input  logic peak,
  input  logic ack_m,
  input  logic ack_c,
  output logic cm_s,
  output logic cc_s,
  output logic peak_s,
  output logic req_m,
  output logic req_c,
  output logic peak_chg
);

  logic [NUM_IN-1:0]  raw;
  logic [NUM_IN-1:0]  stable;
  logic [NUM_IN-1:0]  rise;
  logic [NUM_IN-1:0]  fall;
  logic [NUM_DIR-1:0] press;
  logic [NUM_DIR-1:0] ack;
  logic [NUM_DIR-1:0] press_ok;
  logic [NUM_DIR-1:0] req;

  always_comb begin
    raw           = '0;
    raw[IDX_CM]   = Cm;
    raw[IDX_CC]   = Cc;
    raw[IDX_PQM]  = PQm;
    raw[IDX_PQC]  = PQc;
    raw[IDX_PEAK] = peak;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_db
      debounce_cell #(
        .DB_CYCLES(DB_CYCLES)
      ) u_db (
        .clk (clk),
        .rst (rst),
        .din (raw[gi]),
        .dout(stable[gi]),
        .rise(rise[gi]),
        .fall(fall[gi])
      );
    end
  endgenerate

  assign press[DIR_M] = rise[IDX_PQM];
  assign press[DIR_C] = rise[IDX_PQC];
  assign ack[DIR_M]   = ack_m;
  assign ack[DIR_C]   = ack_c;

  // Only the pedestrian rises and the peak edges drive logic here.
  logic unused_edges;
  assign unused_edges = ^{rise[IDX_CM], rise[IDX_CC], fall[IDX_CM],
                          fall[IDX_CC], fall[IDX_PQM], fall[IDX_PQC]};

`ifdef TRAFFIC_PQ_HOLDOFF_EN
  localparam logic [15:0] HOLD_LOAD = 16'(HOLDOFF_CYCLES);

  logic [NUM_DIR-1:0][15:0] hold_cnt;

  // A press landing on the cycle the lockout reaches zero is accepted.
  always_comb begin
    press_ok = '0;
    for (int d = 0; d < NUM_DIR; d++) begin
      press_ok[d] = press[d] && (hold_cnt[d] == 16'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_cnt <= '0;
    end else begin
      for (int d = 0; d < NUM_DIR; d++) begin
        if (!press_ok[d] && ack[d] && req[d]) begin
          hold_cnt[d] <= HOLD_LOAD;
        end else if (hold_cnt[d] != 16'd0) begin
          hold_cnt[d] <= hold_cnt[d] - 16'd1;
        end
      end
    end
  end
`else
  logic [15:0] unused_holdoff;
  assign unused_holdoff = 16'(HOLDOFF_CYCLES);
  assign press_ok       = press;
`endif

  // request latch stage: a new press wins over a coincident acknowledge
  always_ff @(posedge clk) begin
    if (!rst) begin
      req      <= '0;
      peak_chg <= 1'b0;
    end else begin
      peak_chg <= rise[IDX_PEAK] | fall[IDX_PEAK];
      for (int d = 0; d < NUM_DIR; d++) begin
        if (press_ok[d]) begin
          req[d] <= 1'b1;
        end else if (ack[d]) begin
          req[d] <= 1'b0;
        end
      end
    end
  end

  assign cm_s   = stable[IDX_CM];
  assign cc_s   = stable[IDX_CC];
  assign peak_s = stable[IDX_PEAK];
  assign req_m  = req[DIR_M];
  assign req_c  = req[DIR_C];

endmodule

// File: tb/tb_ped_req_cond.sv
// ---------------------------------------------------------------------------
// tb_ped_req_cond
// Directed bench for ped_req_cond with DB_CYCLES=4, HOLDOFF_CYCLES=8.
// Inputs are driven 1 ns after each rising edge and outputs observed there.
// ---------------------------------------------------------------------------
module tb_ped_req_cond;

  logic clk = 1'b0;
  logic rst, Cm, Cc, PQm, PQc, peak, ack_m, ack_c;
  logic cm_s, cc_s, peak_s, req_m, req_c, peak_chg;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  ped_req_cond #(
    .DB_CYCLES     (4),
    .HOLDOFF_CYCLES(8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .Cm      (Cm),
    .Cc      (Cc),
    .PQm     (PQm),
    .PQc     (PQc),
    .peak    (peak),
    .ack_m   (ack_m),
    .ack_c   (ack_c),
    .cm_s    (cm_s),
    .cc_s    (cc_s),
    .peak_s  (peak_s),
    .req_m   (req_m),
    .req_c   (req_c),
    .peak_chg(peak_chg)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {2'b00, cm_s, cc_s, peak_s, req_m, req_c, peak_chg};
  endfunction

  initial begin
    rst = 1'b0; Cm = 1'b0; Cc = 1'b0; PQm = 1'b0; PQc = 1'b0;
    peak = 1'b0; ack_m = 1'b0; ack_c = 1'b0;
    tick(2);
    chk("reset_outputs", outs(), 8'h00);
    rst = 1'b1;

    // vehicle sensor: debounced exactly 6 edges after the change
    Cm = 1'b1;
    tick(5);
    chk("cm_latency_5", outs(), 8'h00);
    tick(1);
    chk("cm_latency_6", outs(), 8'h20);
    Cm = 1'b0;
    tick(6);
    chk("cm_fall", outs(), 8'h00);

    // short button glitches never debounce
    for (int k = 0; k < 5; k++) begin
      PQm = 1'b1; tick(3);
      PQm = 1'b0; tick(1);
    end
    tick(8);
    chk("pqm_glitch", outs(), 8'h00);

    // peak change pulse on both edges
    peak = 1'b1;
    tick(6);
    chk("peak_rise_s", outs(), 8'h08);
    tick(1);
    chk("peak_rise_chg", outs(), 8'h09);
    tick(1);
    chk("peak_chg_1cyc", outs(), 8'h08);
    peak = 1'b0;
    tick(7);
    chk("peak_fall_chg", outs(), 8'h01);
    tick(1);
    chk("peak_fall_done", outs(), 8'h00);

    // held press latches, ack clears
    PQm = 1'b1;
    tick(6);
    chk("reqm_not_yet", {7'd0, req_m}, 8'h00);
    tick(1);
    chk("reqm_set", outs(), 8'h04);
    tick(3);
    PQm = 1'b0;
    tick(8);
    chk("reqm_hold", outs(), 8'h04);
    ack_m = 1'b1; tick(1); ack_m = 1'b0;
    chk("reqm_ack_clear", outs(), 8'h00);

    // country press; rise coincident with ack keeps the request
    PQc = 1'b1;
    tick(7);
    chk("reqc_set", outs(), 8'h02);
    PQc = 1'b0;
    tick(8);
    PQc = 1'b1;
    tick(6);
    ack_c = 1'b1; tick(1); ack_c = 1'b0;
    chk("reqc_press_wins", outs(), 8'h02);
    PQc = 1'b0;
    tick(8);
    ack_c = 1'b1; tick(1); ack_c = 1'b0;
    chk("reqc_ack_clear", outs(), 8'h00);
    ack_c = 1'b1; tick(1); ack_c = 1'b0;
    chk("reqc_ack_idle", outs(), 8'h00);

    // holdoff window behaviour
    tick(10);
    PQm = 1'b1;
    tick(7);
    chk("ho_reqm_set", outs(), 8'h04);
    PQm = 1'b0;
    tick(8);
    PQm = 1'b1;
    tick(2);
    ack_m = 1'b1; tick(1); ack_m = 1'b0;
    chk("ho_cleared", {7'd0, req_m}, 8'h00);
    tick(4);
`ifdef TRAFFIC_PQ_HOLDOFF_EN
    chk("ho_press_3", {7'd0, req_m}, 8'h00);
`else
    chk("ho_press_3", {7'd0, req_m}, 8'h01);
`endif
    PQm = 1'b0;
    tick(8);
    ack_m = 1'b1; tick(1); ack_m = 1'b0;
    chk("ho_cleared2", {7'd0, req_m}, 8'h00);
    tick(2);
    PQm = 1'b1;
    tick(6);
    chk("ho_press_8_pre", {7'd0, req_m}, 8'h00);
    tick(1);
    chk("ho_press_8", {7'd0, req_m}, 8'h01);

    // reset mid-debounce with a pending request
    Cm = 1'b1;
    tick(3);
    rst = 1'b0; tick(1); rst = 1'b1;
    chk("rst_mid", outs(), 8'h00);
    tick(5);
    chk("rst_restart_5", outs(), 8'h00);
    tick(1);
    chk("rst_restart_6", outs(), 8'h20);
    tick(1);
    chk("rst_reqm_again", outs(), 8'h24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
